// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the alu_pipe block: opcode mnemonics, opcode constants and flag bundle.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        RSH = 3'd1,
        XOR = 3'd2,
        AND = 3'd3,
        CLR = 3'd4,
        CMP = 3'd5,
        BRE = 3'd6,
        MOV = 3'd7
    } op_mne;

    localparam logic [2:0] OPC_ADD = 3'd0;
    localparam logic [2:0] OPC_RSH = 3'd1;
    localparam logic [2:0] OPC_XOR = 3'd2;
    localparam logic [2:0] OPC_AND = 3'd3;
    localparam logic [2:0] OPC_CLR = 3'd4;
    localparam logic [2:0] OPC_CMP = 3'd5;
    localparam logic [2:0] OPC_BRE = 3'd6;
    localparam logic [2:0] OPC_MOV = 3'd7;

    typedef struct packed {
        logic carry;
        logic zero;
        logic lt;
    } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, next flag values and branch decision.
// Define ALU_PIPE_SIGNED_CMP_EN to make CMP's lt a signed comparison.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned SHW = $clog2(W)
) (
    input  op_mne          i_op,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  flags_t         i_flags,
    output logic [W-1:0]   o_result,
    output flags_t         o_flags,
    output logic           o_taken
);

    logic [W:0]   w_sum;
    logic         w_lt;
    logic [W-1:0] w_rsh;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

`ifdef ALU_PIPE_SIGNED_CMP_EN
    assign w_lt = $signed(i_a) < $signed(i_b);
`else
    assign w_lt = i_a < i_b;
`endif

    // Shift amounts of W or more flush every bit out.
    assign w_rsh = (i_b >= W'(W)) ? '0 : (i_a >> i_b[SHW-1:0]);

    always_comb begin
        o_result = '0;
        o_flags  = i_flags;
        o_taken  = 1'b0;
        case (i_op)
            ADD: begin
                o_result      = w_sum[W-1:0];
                o_flags.carry = w_sum[W];
                o_flags.zero  = (w_sum[W-1:0] == '0);
            end
            RSH: o_result = w_rsh;
            XOR: o_result = i_a ^ i_b;
            AND: o_result = i_a & i_b;
            CLR: o_flags  = '0;
            CMP: begin
                o_result     = i_a;
                o_flags.zero = (i_a == i_b);
                o_flags.lt   = w_lt;
            end
            BRE: o_taken  = i_flags.zero;
            MOV: o_result = i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshake; owns result, branch and flag registers.
// Optional build macro: ALU_PIPE_SIGNED_CMP_EN (signed CMP less-than, handled in alu_core).
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  op_mne        in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_carry,
    output logic         out_zero,
    output logic         out_lt,
    output logic         out_taken
);

    localparam int unsigned SHW = $clog2(W);

    logic         r_valid;
    logic [W-1:0] r_result;
    logic         r_taken;
    flags_t       r_flags;

    logic         w_accept;
    logic [W-1:0] w_result;
    logic         w_taken;
    flags_t       w_flags;

    alu_core #(
        .W   (W),
        .SHW (SHW)
    ) u_core (
        .i_op     (in_op),
        .i_a      (in_a),
        .i_b      (in_b),
        .i_flags  (r_flags),
        .o_result (w_result),
        .o_flags  (w_flags),
        .o_taken  (w_taken)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A new accept takes priority over a consume so back-to-back results stream without a bubble.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_taken  <= 1'b0;
            r_flags  <= '0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_result;
            r_taken  <= w_taken;
            r_flags  <= w_flags;
        end else if (r_valid && out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_taken  = r_taken;
    assign out_carry  = r_flags.carry;
    assign out_zero   = r_flags.zero;
    assign out_lt     = r_flags.lt;

endmodule
